regfile_dump_ctrl: RTL and testbench
====================================

# regfile_dump_ctrl

Post-halt register-file dump sequencer for the KGP miniRISC wrapper. Once the core asserts `halt`, the block takes the register-file read port and shows one register at a time on `out`. It advances to the next register on each debounced press of the board `button`, wrapping after the last register. While the core runs, it leaves the read port to the core.

## Interface
- `NUM_REGS`, 16, number of registers dumped; must be a power of two, at least 2.
- `DATA_W`, 32, register width.
- `DEBOUNCE_CYCLES`, 4, consecutive stable synchronized samples required before the debounced button level changes; at least 1.
- `AW`, $clog2(NUM_REGS), address width (derived).
- `clk`  in  1  system clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `button`  in  1  raw, asynchronous push-button.
- `halt`  in  1  level from the core, synchronous to `clk`; 1 = core stopped.
- `dbg_grant`  out  1  1 = this block owns the register-file read port (the wrapper muxes address/enable on it).
- `rf_rd_en`  out  1  read strobe to the register file.
- `rf_rd_addr`  out  AW  read address.
- `rf_rd_data`  in  DATA_W  read data, valid the cycle after `rf_rd_en`.
- `out`  out  DATA_W  displayed register value.
- `out_valid`  out  1  `out` holds a freshly captured value.
- `cur_idx`  out  AW  index of the register currently displayed.

## Operation
- **Button path:**
  - 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synchronized level differs from the debounced level and clears when they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized value and the counter clears.
  - `press` is a 1-cycle pulse on the debounced level's rising edge.
- **FSM states:** IDLE, FETCH, CAPTURE, SHOW.
- **IDLE:**
  - `dbg_grant=0`, `rf_rd_en=0`, `out_valid=0`, `idx=0`.
  - On `halt=1`, go to FETCH.
- **FETCH:** `rf_rd_en=1`, `rf_rd_addr=idx`; go to CAPTURE.
- **CAPTURE:** `out <= rf_rd_data`, `cur_idx <= idx`; go to SHOW.
- **SHOW:**
  - `out_valid=1`.
  - On `press`: `idx <= (idx==NUM_REGS-1) ? 0 : idx+1`; go to FETCH.
- `dbg_grant=1` in FETCH, CAPTURE and SHOW.
- `rf_rd_addr` equals `idx` in every state; it is 0 in IDLE.
- **Halt dropped:** if `halt=0` in any non-IDLE state, go to IDLE next cycle. This takes priority over `press` and over the CAPTURE latch. `out` clears to 0, `cur_idx` to 0, `out_valid` to 0.
- **Ignored presses:** presses in IDLE, FETCH or CAPTURE are dropped, not queued.
- **Halt held:** no re-fetch occurs without a press; `out` is stable.

## Timing
- **Reset values:** `out=0`, `out_valid=0`, `cur_idx=0`, `dbg_grant=0`, `rf_rd_en=0`, `rf_rd_addr=0`. State is IDLE, debounced level 0, counter 0, synchronizer flops 0.
- **Halt to display:**
  - `halt` first sampled 1 at edge E.
  - FETCH (`rf_rd_en=1`) is visible after E.
  - CAPTURE follows after E+1.
  - `out`/`out_valid` are valid after E+2.
- **Button latency:**
  - Raw `button` rises and stays stable.
  - The synchronized level changes 2 edges later.
  - The debounced level rises `DEBOUNCE_CYCLES` edges after that, giving the `press` pulse.
  - `out_valid` drops the cycle after `press`.
  - New `out` is valid 3 edges after the `press` cycle.
- **Glitches:** a raw glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no `press`.
- **Release:** button release produces no `press`.
- **Wrap:** a press at `idx=NUM_REGS-1` fetches register 0.
- **Mid-operation reset:** asynchronous `rst` mid-dump immediately forces all reset values, independent of the clock.
- **Data path width:** `rf_rd_data` is latched exactly, with no sign or width conversion.

## Test plan
- **Reset and idle:** `rst=1` then 0 with `halt=0`, button toggling -> `out=0`, `out_valid=0`, `dbg_grant=0`, `rf_rd_en` never 1.
- **Halt entry:** model RF with reg[i]=i*3, except reg[0]=-5. Raise `halt` -> `rf_rd_en` pulses once with addr 0. `out` becomes 32'hFFFFFFFB with `out_valid=1` exactly 3 edges after `halt` is sampled.
- **Stepping and wrap:** `halt=1`, 16 clean presses (each held and released 20 cycles, `DEBOUNCE_CYCLES=4`) -> `cur_idx` goes 1..15 then 0. `out` goes 3, 6, ..., 45, then 32'hFFFFFFFB. Each update lands 3 edges after its `press`.
- **Bounce filter:**
  - Button pulses of 1, 2 and 3 cycles plus chatter of 1-cycle toggles -> no index change.
  - A 4-cycle stable-high press -> exactly one advance.
- **Halt drop mid-dump:** deassert `halt` in the CAPTURE cycle of register 5 -> next cycle IDLE, `out=0`, `cur_idx=0`, `dbg_grant=0`. Re-raise -> dump restarts at register 0.
- **Async reset in SHOW:** assert `rst` between clock edges while showing register 7 -> all outputs at reset values before the next edge. After release with `halt=1`, register 0 is displayed 3 edges later.

Source files
------------

// File: rtl/regfile_dump_ctrl.sv
// Post-halt register-file dump sequencer: takes the RF read port while the core is halted and
// shows one register at a time on `out`, stepping on each debounced button press.
module regfile_dump_ctrl #(
  parameter int unsigned NUM_REGS        = 16,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned AW              = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              halt,
  output logic              dbg_grant,
  output logic              rf_rd_en,
  output logic [AW-1:0]     rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic [AW-1:0]     cur_idx
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StCapture, StShow} state_e;

  logic [1:0]    sync_q;
  logic          deb_q;
  logic [CW-1:0] cnt_q;
  logic          press;
  state_e        state_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] idx_next;

  // Counter counts consecutive samples where the synchronized level disagrees with the
  // debounced one; the level flips on the DEBOUNCE_CYCLES-th such sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button};
      press  <= 1'b0;
      if (sync_q[1] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_q <= sync_q[1];
        cnt_q <= '0;
        press <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign idx_next = (idx_q == AW'(NUM_REGS - 1)) ? '0 : idx_q + AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      dbg_grant  <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_rd_addr <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      cur_idx    <= '0;
    end else if (state_q != StIdle && !halt) begin
      // Losing halt wins over a pending press or capture.
      state_q    <= StIdle;
      idx_q      <= '0;
      dbg_grant  <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_rd_addr <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      cur_idx    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          idx_q      <= '0;
          out_valid  <= 1'b0;
          rf_rd_addr <= '0;
          if (halt) begin
            state_q   <= StFetch;
            dbg_grant <= 1'b1;
            rf_rd_en  <= 1'b1;
          end
        end
        StFetch: begin
          rf_rd_en <= 1'b0;
          state_q  <= StCapture;
        end
        StCapture: begin
          out       <= rf_rd_data;
          cur_idx   <= idx_q;
          out_valid <= 1'b1;
          state_q   <= StShow;
        end
        StShow: begin
          if (press) begin
            idx_q      <= idx_next;
            rf_rd_addr <= idx_next;
            rf_rd_en   <= 1'b1;
            out_valid  <= 1'b0;
            state_q    <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: stimulus pushes expected displays, a negedge monitor
// pops and checks them whenever out_valid rises.
module tb_regfile_dump_ctrl;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DEB      = 4;
  localparam int unsigned AW       = 4;
  // Raw rise -> 2 sync edges -> DEB debounce edges -> press cycle -> fetch -> capture.
  localparam int unsigned BTN_LAT  = 2 + DEB + 3;
  localparam int unsigned HALT_LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              button;
  logic              halt;
  logic              dbg_grant;
  logic              rf_rd_en;
  logic [AW-1:0]     rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic [AW-1:0]     cur_idx;

  regfile_dump_ctrl #(
    .NUM_REGS       (NUM_REGS),
    .DATA_W         (DATA_W),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .halt      (halt),
    .dbg_grant (dbg_grant),
    .rf_rd_en  (rf_rd_en),
    .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data),
    .out       (out),
    .out_valid (out_valid),
    .cur_idx   (cur_idx)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [NUM_REGS];
  always @(posedge clk) if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] data;
    int unsigned       due;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rd_en_cnt = 0;
  int   model_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  initial begin : monitor
    exp_t e;
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rf_rd_en) begin
        rd_en_cnt++;
        if (exp_q.size() > 0) check("rd_addr", rf_rd_addr, exp_q[0].idx);
      end
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_display", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out, e.data);
          check("cur_idx", cur_idx, e.idx);
          check("latency", cyc, e.due);
          check("grant_in_show", dbg_grant, 1);
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_display(input int idx, input int unsigned lat);
    exp_t e;
    e.idx  = AW'(idx);
    e.data = mem[idx];
    e.due  = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic press(input int hold, input int rel);
    model_idx = (model_idx + 1) % NUM_REGS;
    expect_display(model_idx, BTN_LAT);
    button = 1'b1;
    tick(hold);
    button = 1'b0;
    tick(rel);
  endtask

  task automatic glitch(input int len);
    button = 1'b1;
    tick(len);
    button = 1'b0;
    tick(10);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick(1);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"}, out, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_cur_idx"}, cur_idx, 0);
    check({tag, "_dbg_grant"}, dbg_grant, 0);
    check({tag, "_rf_rd_en"}, rf_rd_en, 0);
    check({tag, "_rf_rd_addr"}, rf_rd_addr, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int saved;
    rst    = 1'b1;
    button = 1'b0;
    halt   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mem[i] = DATA_W'(i * 3);
    mem[0] = -32'sd5;
    tick(3);
    check_reset_outputs("reset");

    // Idle: button activity with the core running must not touch the read port.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      button = 1'b1;
      tick($urandom_range(2, 12));
      button = 1'b0;
      tick(12);
    end
    check("idle_rd_en_count", rd_en_cnt, 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_grant", dbg_grant, 0);
    check("idle_out", out, 0);

    // Halt entry
    model_idx = 0;
    expect_display(0, HALT_LAT);
    halt = 1'b1;
    drain();
    check("entry_rd_en_count", rd_en_cnt, 1);
    check("entry_reg0", out, 32'hFFFF_FFFB);

    // Stepping through all registers and wrapping
    for (int i = 0; i < NUM_REGS; i++) press(20, 20);
    drain();
    check("wrap_idx", cur_idx, 0);
    check("wrap_out", out, 32'hFFFF_FFFB);
    check("step_rd_en_count", rd_en_cnt, 1 + NUM_REGS);

    // Bounce filter
    saved = rd_en_cnt;
    glitch(1);
    glitch(2);
    glitch(3);
    for (int i = 0; i < 6; i++) begin
      button = 1'b1;
      tick(1);
      button = 1'b0;
      tick(1);
    end
    tick(10);
    check("bounce_no_fetch", rd_en_cnt, saved);
    check("bounce_idx", cur_idx, AW'(model_idx));
    press(DEB, 20);
    drain();
    check("min_press_idx", cur_idx, 1);

    // Halt dropped in the capture cycle of register 5
    while (model_idx != 4) press(20, 20);
    drain();
    button = 1'b1;
    for (int i = 0; i < 30 && !rf_rd_en; i++) tick(1);
    check("drop_fetch_seen", rf_rd_en, 1);
    check("drop_fetch_addr", rf_rd_addr, 5);
    tick(1);
    halt = 1'b0;
    tick(1);
    check("drop_out", out, 0);
    check("drop_cur_idx", cur_idx, 0);
    check("drop_grant", dbg_grant, 0);
    check("drop_out_valid", out_valid, 0);
    button = 1'b0;
    tick(20);
    for (int i = 0; i < NUM_REGS; i++) mem[i] = $urandom;
    model_idx = 0;
    expect_display(0, HALT_LAT);
    halt = 1'b1;
    drain();

    // Randomized mix of clean presses and sub-threshold glitches
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, DEB - 1));
      else press($urandom_range(DEB, 12), $urandom_range(12, 20));
    end
    drain();
    check("random_idx", cur_idx, AW'(model_idx));

    // Asynchronous reset while showing register 7
    while (model_idx != 7) press(20, 20);
    drain();
    tick(3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_idx = 0;
    expect_display(0, HALT_LAT);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
